avalon_sdram_arbiter: RTL
=========================

# avalon_sdram_arbiter

Two-requester Avalon-MM arbiter that shares one SDRAM-facing master port between two copy/DMA accelerators. It serialises read and write commands from requesters m0 and m1 onto the single `sdram_*` port. Each granted command is held until the SDRAM accepts it. Read responses are routed back to the requester that issued them, using an in-order owner-tag FIFO. The block sits between the accelerators' master ports and the SDRAM controller's slave port.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 4: depth of the read owner-tag FIFO, i.e. the maximum number of accepted reads still awaiting `readdatavalid`. Power of two, ≥2.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `mN_waitrequest` out 1 (N=0,1): low only in the cycle requester N's command is accepted.
- `mN_address` in 32: requester N byte address.
- `mN_read` in 1: requester N read request.
- `mN_write` in 1: requester N write request.
- `mN_writedata` in 32: requester N write data.
- `mN_readdata` out 32: equals `sdram_readdata`, broadcast to both requesters.
- `mN_readdatavalid` out 1: `sdram_readdatavalid` qualified by the head owner tag.
- `sdram_waitrequest` in 1: SDRAM stall.
- `sdram_address` out 32: forwarded address.
- `sdram_read` out 1: forwarded read.
- `sdram_write` out 1: forwarded write.
- `sdram_writedata` out 32: forwarded write data.
- `sdram_readdata` in 32: SDRAM read data.
- `sdram_readdatavalid` in 1: SDRAM read data valid.
- `outstanding` out $clog2(MAX_OUTSTANDING+1): current FIFO occupancy.
- `err_orphan` out 1: sticky flag; set by `readdatavalid` while the FIFO is empty; cleared only by reset.

## Operation
- States: `IDLE`, `GRANT0`, `GRANT1`.
- A requester is *eligible* if it asserts `write`, or asserts `read` while `outstanding < MAX_OUTSTANDING`.
- `IDLE`: `sdram_read`, `sdram_write` = 0; `sdram_address`, `sdram_writedata` = 0; both `mN_waitrequest` = 1.
  - Exactly one eligible requester: go to its `GRANTn`.
  - Both eligible: the requester not equal to `last_grant` wins.
  - `last_grant` updates on every grant.
- `GRANTn`: `sdram_*` command outputs combinationally mirror requester n.
  - `mn_waitrequest` = `sdram_waitrequest`; the other requester's waitrequest = 1.
  - Acceptance means (`read` | `write`) && !`sdram_waitrequest`; on acceptance go to `IDLE`.
  - If requester n drops both `read` and `write` (protocol violation), go to `IDLE` with nothing pushed.
  - If requester n asserts both `read` and `write`, forward only the write; the read is not forwarded and no tag is pushed.
- Tag FIFO:
  - An accepted read pushes tag n.
  - `sdram_readdatavalid` pops the head tag and drives `m<head>_readdatavalid` = 1 that cycle.
  - Push and pop in the same cycle leave `outstanding` unchanged; both pointers advance and wrap modulo `MAX_OUTSTANDING`.
  - `readdatavalid` with FIFO empty: no pop, no `mN_readdatavalid`, set `err_orphan`.
- Writes never touch the FIFO and are never blocked by FIFO state.
- Reset mid-operation: state → `IDLE`, FIFO emptied, `last_grant` = 1, `err_orphan` = 0. Responses arriving after reset count as orphans.
- Reset values of outputs:
  - `sdram_read`, `sdram_write` = 0; `sdram_address`, `sdram_writedata` = 0.
  - `m0_waitrequest`, `m1_waitrequest` = 1.
  - `mN_readdatavalid` = 0; `outstanding` = 0; `err_orphan` = 0.

## Timing
- Eligible request sampled in `IDLE` at edge N → command on the `sdram_*` port during cycle N+1.
- If `sdram_waitrequest` = 0 in cycle N+1, the command is accepted and `mn_waitrequest` = 0 in that cycle; state is `IDLE` at N+2.
- Minimum of 2 cycles per command: one arbitration bubble per transaction.
- `readdatavalid` routing is combinational, with zero added latency; `mN_readdata` is unregistered.
- `outstanding` and `err_orphan` update on the edge following the event.

## Configuration
- `ARB_FIXED_PRIORITY_EN` defined: m0 always wins when both are eligible; `last_grant` is unused.
- `ARB_FIXED_PRIORITY_EN` undefined (default): round-robin as described under Operation.

## Test plan
- **Reset**, then m0 read to 0x100 with `sdram_waitrequest` = 0: `sdram_read` = 1 and `sdram_address` = 0x100 in cycle 1. `m0_waitrequest` = 0 in cycle 1. `outstanding` = 1. `readdatavalid` with data 0xDEADBEEF then pulses `m0_readdatavalid` only, with `m0_readdata` = 0xDEADBEEF.
- **Contention:** m0 and m1 write continuously (0xA0/0x11, 0xB0/0x22). Grants alternate m0, m1, m0, m1, one command every 2 cycles. With `ARB_FIXED_PRIORITY_EN` defined, m0 gets every grant.
- **Stall:** m1 write with `sdram_waitrequest` held 1 for 5 cycles. `sdram_write`, `sdram_address` and `sdram_writedata` stay stable and `m1_waitrequest` stays 1 for all 5 cycles. Acceptance occurs in cycle 6; m0 requests are ignored throughout.
- **FIFO full:** 4 m0 reads accepted with no responses returned. `outstanding` = 4. A further m1 read is not granted. An m1 write still completes. One `readdatavalid` returns `outstanding` to 3, and the m1 read is then granted.
- **Ordering:** reads issued in order m0, m1, m0 (the m0 reads may be back-to-back), then 3 `readdatavalid` pulses. Valids are routed m0, m1, m0. A push and a pop in the same cycle keep `outstanding` unchanged, and pointers wrap correctly.
- **Orphan and reset:** `readdatavalid` with FIFO empty sets `err_orphan` = 1 and pulses no requester. Asserting `rst_n` = 0 while in `GRANT1` returns all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/avalon_sdram_arbiter.sv
// avalon_sdram_arbiter: shares one SDRAM-facing Avalon-MM master port between
// two requesters (m0, m1). Commands are serialised through IDLE/GRANT0/GRANT1
// and read responses are steered back through an in-order owner-tag FIFO.
// Build option: define ARB_FIXED_PRIORITY_EN to make m0 win every tie;
// otherwise ties are resolved round-robin against the last grant.
module avalon_sdram_arbiter #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   output logic                                 m0_waitrequest,
   input  logic [31:0]                          m0_address,
   input  logic                                 m0_read,
   input  logic                                 m0_write,
   input  logic [31:0]                          m0_writedata,
   output logic [31:0]                          m0_readdata,
   output logic                                 m0_readdatavalid,
   output logic                                 m1_waitrequest,
   input  logic [31:0]                          m1_address,
   input  logic                                 m1_read,
   input  logic                                 m1_write,
   input  logic [31:0]                          m1_writedata,
   output logic [31:0]                          m1_readdata,
   output logic                                 m1_readdatavalid,
   input  logic                                 sdram_waitrequest,
   output logic [31:0]                          sdram_address,
   output logic                                 sdram_read,
   output logic                                 sdram_write,
   output logic [31:0]                          sdram_writedata,
   input  logic [31:0]                          sdram_readdata,
   input  logic                                 sdram_readdatavalid,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
   output logic                                 err_orphan
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic                       last_grant_q, last_grant_d;
   logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       err_orphan_q, err_orphan_d;

   logic m0_elig_s, m1_elig_s;
   logic cmd_s, rd_only_s, accept_s, push_s, push_tag_s;
   logic fifo_empty_s, pop_s, orphan_s, head_tag_s;

   // Read data is a plain broadcast; only the valid strobe is steered.
   assign m0_readdata = sdram_readdata;
   assign m1_readdata = sdram_readdata;
   assign outstanding = cnt_q;
   assign err_orphan  = err_orphan_q;

   // Eligibility: writes always, reads only while a tag slot is free.
   always_comb begin
      m0_elig_s = m0_write | (m0_read & (cnt_q < CNT_MAX));
      m1_elig_s = m1_write | (m1_read & (cnt_q < CNT_MAX));
   end

   // Decode the granted command: acceptance, and whether it pushes a read tag.
   always_comb begin
      cmd_s      = 1'b0;
      rd_only_s  = 1'b0;
      push_tag_s = 1'b0;
      case (state_q)
         GRANT0: begin
            cmd_s      = m0_read | m0_write;
            rd_only_s  = m0_read & ~m0_write;
            push_tag_s = 1'b0;
         end
         GRANT1: begin
            cmd_s      = m1_read | m1_write;
            rd_only_s  = m1_read & ~m1_write;
            push_tag_s = 1'b1;
         end
         default: begin
            cmd_s      = 1'b0;
            rd_only_s  = 1'b0;
            push_tag_s = 1'b0;
         end
      endcase
      accept_s = cmd_s & ~sdram_waitrequest;
      push_s   = accept_s & rd_only_s;
   end

   // Next-state and last-grant selection.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (m0_elig_s && m1_elig_s) begin
`ifdef ARB_FIXED_PRIORITY_EN
               state_d      = GRANT0;
               last_grant_d = 1'b0;
`else
               // Round-robin: the requester that was not granted last wins.
               if (last_grant_q) begin
                  state_d      = GRANT0;
                  last_grant_d = 1'b0;
               end else begin
                  state_d      = GRANT1;
                  last_grant_d = 1'b1;
               end
`endif
            end else if (m0_elig_s) begin
               state_d      = GRANT0;
               last_grant_d = 1'b0;
            end else if (m1_elig_s) begin
               state_d      = GRANT1;
               last_grant_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT0, GRANT1: begin
            // Leave on acceptance, or when the requester abandons its command.
            if (!cmd_s || accept_s) begin
               state_d = IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Command port mirrors the granted requester; IDLE drives a quiet bus.
   always_comb begin
      sdram_address   = 32'h0;
      sdram_writedata = 32'h0;
      sdram_read      = 1'b0;
      sdram_write     = 1'b0;
      m0_waitrequest  = 1'b1;
      m1_waitrequest  = 1'b1;
      case (state_q)
         GRANT0: begin
            sdram_address   = m0_address;
            sdram_writedata = m0_writedata;
            sdram_write     = m0_write;
            sdram_read      = m0_read & ~m0_write;
            m0_waitrequest  = ~accept_s;
         end
         GRANT1: begin
            sdram_address   = m1_address;
            sdram_writedata = m1_writedata;
            sdram_write     = m1_write;
            sdram_read      = m1_read & ~m1_write;
            m1_waitrequest  = ~accept_s;
         end
         default: begin
            sdram_read  = 1'b0;
            sdram_write = 1'b0;
         end
      endcase
   end

   // Owner-tag FIFO: push on accepted read, pop on response, flag orphans.
   always_comb begin
      fifo_empty_s = (cnt_q == {CNT_W{1'b0}});
      head_tag_s   = tag_q[rd_ptr_q];
      pop_s        = sdram_readdatavalid & ~fifo_empty_s;
      orphan_s     = sdram_readdatavalid & fifo_empty_s;
      m0_readdatavalid = pop_s & ~head_tag_s;
      m1_readdatavalid = pop_s & head_tag_s;
      tag_d        = tag_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      err_orphan_d = err_orphan_q | orphan_s;
      if (push_s) begin
         tag_d[wr_ptr_q] = push_tag_s;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         tag_q        <= {MAX_OUTSTANDING{1'b0}};
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         cnt_q        <= {CNT_W{1'b0}};
         err_orphan_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         tag_q        <= tag_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         err_orphan_q <= err_orphan_d;
      end
   end

endmodule
